// File: rtl/seq_mult_unit.sv
// seq_mult_unit: radix-2 shift-add sequential multiplier with start/done.
// WIDTH-bit operands, 2*WIDTH-bit product, WIDTH iterations per operation.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   tc       two's-complement select (only when SEQ_MULT_SIGNED_EN is defined)
//   start    request, sampled only while idle
//   a_in     multiplier operand, captured on accepted start
//   b_in     multiplicand operand, captured on accepted start
//   busy     high while an operation is in flight (RUN or DONE)
//   done     one-cycle pulse, product valid
//   product  {Preg, Areg}, held until the next accepted start
//
// Optional feature macro: SEQ_MULT_SIGNED_EN (adds tc port, signed mode).

module seq_mult_unit #(
    parameter int WIDTH = 24
) (
    input  logic               clk,
    input  logic               rst,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic               tc,
`endif
    input  logic               start,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] preg;
    logic [CNT_W-1:0] cnt;
    logic             tc_q;

    logic             last;
    logic             sub;
    logic [WIDTH:0]   pext;
    logic [WIDTH:0]   bext;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;

`ifdef SEQ_MULT_SIGNED_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tc_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            tc_q <= tc;
        end
    end
`else
    assign tc_q = 1'b0;
`endif

    assign last = (cnt == CNT_W'(WIDTH - 1));

    // The sum is one bit wider than Preg so the carry (unsigned) or the
    // sign (signed) survives the shift. In signed mode the multiplier MSB
    // has negative weight, so its partial product is subtracted.
    always_comb begin
        pext   = {tc_q & preg[WIDTH-1], preg};
        bext   = {tc_q & breg[WIDTH-1], breg};
        sub    = tc_q & areg[0] & last;
        addend = areg[0] ? bext : '0;
        if (sub) begin
            addend = ~bext;
        end
        sum = pext + addend + {{WIDTH{1'b0}}, sub};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            areg  <= '0;
            breg  <= '0;
            preg  <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        areg  <= a_in;
                        breg  <= b_in;
                        preg  <= '0;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    preg <= sum[WIDTH:1];
                    areg <= {sum[0], areg[WIDTH-1:1]};
                    cnt  <= cnt + CNT_W'(1);
                    if (last) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign product = {preg, areg};

endmodule
